// File: rtl/pmod_i2c_target_if.sv
// Open-drain I2C pin bundle between the board pins and the target.
// The target only reads SCL and only pulls SDA low.
interface pmod_i2c_target_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe;

    modport master (output scl_i, output sda_i, input sda_oe);
    modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/pmod_i2c_target.sv
// I2C target with an auto-incrementing pointer into NREGS byte registers.
// Optional SCL/SDA glitch filter: define PMOD_I2C_TARGET_GLITCH_FILTER_EN.
module pmod_i2c_target #(
    parameter logic [6:0]  ADDR  = 7'h42,
    parameter int unsigned NREGS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pmod_i2c_target_if.slave     bus,
    output logic [8*NREGS-1:0]   regs,
    output logic                 wr_stb,
    output logic [7:0]           wr_addr,
    output logic [7:0]           wr_data,
    output logic                 busy
);
    localparam int unsigned IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK
    } state_t;

    state_t     state;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_f, sda_f, scl_p, sda_p;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic       rw, ack_phase;
    logic [7:0] ptr, ptr_next, rd_data, rx_byte;
    logic       in_range;
    logic [7:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_i};
            sda_sync <= {sda_sync[0], bus.sda_i};
        end
    end

`ifdef PMOD_I2C_TARGET_GLITCH_FILTER_EN
    // Window = current synced sample plus two previous; output holds until all agree.
    logic [1:0] scl_hist, sda_hist;
    logic       scl_q, sda_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_q    <= scl_f;
            sda_q    <= sda_f;
        end
    end

    always_comb begin
        scl_f = scl_q;
        sda_f = sda_q;
        if ({scl_hist, scl_sync[1]} == 3'b111 || {scl_hist, scl_sync[1]} == 3'b000) scl_f = scl_sync[1];
        if ({sda_hist, sda_sync[1]} == 3'b111 || {sda_hist, sda_sync[1]} == 3'b000) sda_f = sda_sync[1];
    end
`else
    always_comb begin
        scl_f = scl_sync[1];
        sda_f = sda_sync[1];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_f;
            sda_p <= sda_f;
        end
    end

    logic scl_rise, scl_fall, start_c, stop_c;

    always_comb begin
        scl_rise = scl_f & ~scl_p;
        scl_fall = ~scl_f & scl_p;
        start_c  = scl_f & scl_p & sda_p & ~sda_f;
        stop_c   = scl_f & scl_p & ~sda_p & sda_f;
        in_range = {1'b0, ptr} < 9'(NREGS);
        ptr_next = ({1'b0, ptr} >= 9'(NREGS - 1)) ? '0 : ptr + 8'd1;
        rd_data  = in_range ? mem[ptr[IW-1:0]] : 8'hFF;
        rx_byte  = {shift, sda_f};
    end

    for (genvar n = 0; n < NREGS; n++) begin : g_flat
        assign regs[8*n +: 8] = mem[n];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            rw         <= 1'b0;
            ack_phase  <= 1'b0;
            ptr        <= '0;
            bus.sda_oe <= 1'b0;
            busy       <= 1'b0;
            wr_stb     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            for (int unsigned n = 0; n < NREGS; n++) mem[n] <= '0;
        end else begin
            wr_stb <= 1'b0;
            if (start_c) begin
                state      <= ST_ADDR;
                bit_cnt    <= '0;
                ack_phase  <= 1'b0;
                bus.sda_oe <= 1'b0;
            end else if (stop_c) begin
                state      <= ST_IDLE;
                bit_cnt    <= '0;
                ack_phase  <= 1'b0;
                bus.sda_oe <= 1'b0;
                busy       <= 1'b0;
            end else if (scl_rise) begin
                unique case (state)
                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        shift   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ack_phase <= 1'b0;
                            if (state == ST_ADDR) begin
                                if (rx_byte[7:1] == ADDR) begin
                                    state <= ST_ADDR_ACK;
                                    rw    <= rx_byte[0];
                                    busy  <= 1'b1;
                                end else begin
                                    state <= ST_IDLE;
                                    busy  <= 1'b0;
                                end
                            end else if (state == ST_PTR) begin
                                ptr   <= rx_byte;
                                state <= ST_PTR_ACK;
                            end else begin
                                if (in_range) begin
                                    mem[ptr[IW-1:0]] <= rx_byte;
                                    wr_stb  <= 1'b1;
                                    wr_addr <= ptr;
                                    wr_data <= rx_byte;
                                end
                                ptr   <= ptr_next;
                                state <= ST_WDATA_ACK;
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (sda_f) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            ack_phase <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                unique case (state)
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                        // First fall starts the ACK slot, second fall ends it.
                        if (!ack_phase) begin
                            bus.sda_oe <= 1'b1;
                            ack_phase  <= 1'b1;
                        end else begin
                            ack_phase <= 1'b0;
                            bit_cnt   <= '0;
                            if (state == ST_ADDR_ACK && rw) begin
                                bus.sda_oe <= ~rd_data[7];
                                shift      <= rd_data[6:0];
                                state      <= ST_RDATA;
                            end else begin
                                bus.sda_oe <= 1'b0;
                                state      <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (bit_cnt == 3'd7) begin
                            bus.sda_oe <= 1'b0;
                            ptr        <= ptr_next;
                            bit_cnt    <= '0;
                            ack_phase  <= 1'b0;
                            state      <= ST_RDATA_ACK;
                        end else begin
                            bus.sda_oe <= ~shift[6];
                            shift      <= {shift[5:0], 1'b0};
                            bit_cnt    <= bit_cnt + 3'd1;
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (ack_phase) begin
                            ack_phase  <= 1'b0;
                            bit_cnt    <= '0;
                            bus.sda_oe <= ~rd_data[7];
                            shift      <= rd_data[6:0];
                            state      <= ST_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pmod_i2c_target.sv
// Directed bench: a bit-banged I2C controller model against pmod_i2c_target.
// The glitch test is built only when PMOD_I2C_TARGET_GLITCH_FILTER_EN is defined.
module tb_pmod_i2c_target;
    localparam int Q = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic sda = 1'b1;
    always #5 clk = ~clk;

    pmod_i2c_target_if bus();
    assign bus.scl_i = scl;
    assign bus.sda_i = sda & ~bus.sda_oe;

    logic [127:0] regs;
    logic         wr_stb, busy;
    logic [7:0]   wr_addr, wr_data;

    pmod_i2c_target #(.ADDR(7'h42), .NREGS(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .regs(regs),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] wq_addr[$];
    logic [7:0] wq_data[$];

    always @(negedge clk) if (wr_stb) begin
        wq_addr.push_back(wr_addr);
        wq_data.push_back(wr_data);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda = 1'b1; tick(Q);
        scl = 1'b1; tick(Q);
        sda = 1'b0; tick(Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda = 1'b0; tick(Q);
        scl = 1'b1; tick(Q);
        sda = 1'b1; tick(Q);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda = b; tick(Q);
        scl = 1'b1; tick(Q);
        s = bus.sda_i; tick(Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(nack, s);
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(5);
        if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b exp 0", bus.sda_oe); end
        checks++;
        if ({busy, wr_stb, wr_addr, wr_data} !== 18'd0) begin errors++; $display("FAIL reset_outs got %h exp 0", {busy, wr_stb, wr_addr, wr_data}); end
        checks++;
        if (regs !== 128'd0) begin errors++; $display("FAIL reset_regs got %h exp 0", regs); end
        checks++;
        rst = 1'b0; tick(10);
    endtask

    task automatic test_write_read();
        logic [4:0] acks;
        logic [7:0] d0, d1, d2;
        logic       a;
        wq_addr.delete(); wq_data.delete();
        i2c_start();
        write_byte(8'h84, acks[0]);
        write_byte(8'h02, acks[1]);
        write_byte(8'hA5, acks[2]);
        write_byte(8'h5A, acks[3]);
        write_byte(8'h3C, acks[4]);
        i2c_stop(); tick(5);
        if (acks !== 5'b11111) begin errors++; $display("FAIL wr_acks got %b exp 11111", acks); end
        checks++;
        if (regs[16 +: 24] !== 24'h3C5AA5) begin errors++; $display("FAIL wr_regs got %h exp 3c5aa5", regs[16 +: 24]); end
        checks++;
        if (wq_addr.size() !== 3) begin errors++; $display("FAIL wr_stb_count got %0d exp 3", wq_addr.size()); end
        else begin
            if ({wq_addr[0], wq_addr[1], wq_addr[2]} !== 24'h020304) begin errors++; $display("FAIL wr_addr got %h exp 020304", {wq_addr[0], wq_addr[1], wq_addr[2]}); end
            checks++;
            if ({wq_data[0], wq_data[1], wq_data[2]} !== 24'hA55A3C) begin errors++; $display("FAIL wr_data got %h exp a55a3c", {wq_data[0], wq_data[1], wq_data[2]}); end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_stop got %b exp 0", busy); end
        checks++;

        i2c_start();
        write_byte(8'h84, a);
        write_byte(8'h02, a);
        i2c_start();
        write_byte(8'h85, a);
        if (a !== 1'b1) begin errors++; $display("FAIL rd_addr_ack got %b exp 1", a); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_read got %b exp 1", busy); end
        checks++;
        read_byte(1'b0, d0);
        read_byte(1'b0, d1);
        read_byte(1'b1, d2);
        if ({d0, d1, d2} !== 24'hA55A3C) begin errors++; $display("FAIL rd_data got %h exp a55a3c", {d0, d1, d2}); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_nack got %b exp 0", busy); end
        checks++;
        i2c_stop(); tick(5);
        if (wq_addr.size() !== 3) begin errors++; $display("FAIL rd_no_stb got %0d exp 3", wq_addr.size()); end
        checks++;
    endtask

    task automatic test_mismatch();
        logic a;
        wq_addr.delete(); wq_data.delete();
        i2c_start();
        write_byte(8'h90, a);
        if (a !== 1'b0) begin errors++; $display("FAIL mismatch_ack got %b exp 0", a); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy got %b exp 0", busy); end
        checks++;
        write_byte(8'h11, a);
        i2c_stop(); tick(5);
        if (wq_addr.size() !== 0) begin errors++; $display("FAIL mismatch_stb got %0d exp 0", wq_addr.size()); end
        checks++;
    endtask

    task automatic test_wrap();
        logic       a0, a1, a2;
        logic [7:0] d0, d1;
        wq_addr.delete(); wq_data.delete();
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h0F, a0);
        write_byte(8'h77, a0);
        write_byte(8'h11, a0);
        i2c_stop(); tick(5);
        if (wq_addr.size() !== 2) begin errors++; $display("FAIL wrap_stb_count got %0d exp 2", wq_addr.size()); end
        else if ({wq_addr[0], wq_addr[1]} !== 16'h0F00) begin errors++; $display("FAIL wrap_wr_addr got %h exp 0f00", {wq_addr[0], wq_addr[1]}); end
        checks++;
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h0F, a0);
        i2c_start();
        write_byte(8'h85, a0);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        i2c_stop();
        if ({d0, d1} !== 16'h7711) begin errors++; $display("FAIL wrap_read got %h exp 7711", {d0, d1}); end
        checks++;

        wq_addr.delete(); wq_data.delete();
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h20, a1);
        write_byte(8'h99, a2);
        i2c_stop(); tick(5);
        if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL oor_acks got %b exp 111", {a0, a1, a2}); end
        checks++;
        if (wq_addr.size() !== 0) begin errors++; $display("FAIL oor_stb got %0d exp 0", wq_addr.size()); end
        checks++;
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h20, a0);
        i2c_start();
        write_byte(8'h85, a0);
        read_byte(1'b1, d0);
        i2c_stop();
        if (d0 !== 8'hFF) begin errors++; $display("FAIL oor_read got %h exp ff", d0); end
        checks++;
        if ({regs[0 +: 8], regs[120 +: 8]} !== 16'h1177) begin errors++; $display("FAIL oor_regs got %h exp 1177", {regs[0 +: 8], regs[120 +: 8]}); end
        checks++;
    endtask

    task automatic test_stop_partial();
        logic a, s;
        wq_addr.delete(); wq_data.delete();
        i2c_start();
        write_byte(8'h84, a);
        write_byte(8'h05, a);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        clock_bit(1'b1, s);
        i2c_stop(); tick(5);
        if (wq_addr.size() !== 0) begin errors++; $display("FAIL partial_stb got %0d exp 0", wq_addr.size()); end
        checks++;
        if (regs[40 +: 8] !== 8'h00) begin errors++; $display("FAIL partial_reg got %h exp 00", regs[40 +: 8]); end
        checks++;
        if ({busy, bus.sda_oe} !== 2'b00) begin errors++; $display("FAIL partial_idle got %b exp 00", {busy, bus.sda_oe}); end
        checks++;
        i2c_start();
        write_byte(8'h84, a);
        i2c_stop();
        if (a !== 1'b1) begin errors++; $display("FAIL partial_next_ack got %b exp 1", a); end
        checks++;
    endtask

    task automatic test_reset_rdata();
        logic a, s;
        i2c_start();
        write_byte(8'h84, a);
        write_byte(8'h02, a);
        i2c_start();
        write_byte(8'h85, a);
        clock_bit(1'b1, s);
        if (bus.sda_oe !== 1'b1) begin errors++; $display("FAIL rdata_bit6_drive got %b exp 1", bus.sda_oe); end
        checks++;
        rst = 1'b1;
        @(posedge clk); #1;
        if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL reset_release got %b exp 0", bus.sda_oe); end
        checks++;
        tick(2);
        if ({regs, busy} !== 129'd0) begin errors++; $display("FAIL reset_mid_state got %h exp 0", {regs, busy}); end
        checks++;
        scl = 1'b1; sda = 1'b1; tick(5);
        rst = 1'b0; tick(10);
    endtask

`ifdef PMOD_I2C_TARGET_GLITCH_FILTER_EN
    task automatic test_glitch();
        logic       a, s;
        logic [7:0] b;
        b = 8'hC3;
        wq_addr.delete(); wq_data.delete();
        i2c_start();
        write_byte(8'h84, a);
        write_byte(8'h06, a);
        for (int i = 7; i >= 0; i--) begin
            sda = b[i]; tick(Q);
            scl = 1'b1; tick(Q / 2);
            if (i == 4) begin scl = 1'b0; tick(2); scl = 1'b1; end
            tick(Q);
            scl = 1'b0; tick(Q);
        end
        clock_bit(1'b1, s);
        i2c_stop(); tick(5);
        if (s !== 1'b0) begin errors++; $display("FAIL glitch_ack got %b exp 0", s); end
        checks++;
        if (regs[48 +: 8] !== 8'hC3) begin errors++; $display("FAIL glitch_reg got %h exp c3", regs[48 +: 8]); end
        checks++;
        if (wq_addr.size() !== 1) begin errors++; $display("FAIL glitch_stb got %0d exp 1", wq_addr.size()); end
        checks++;
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_mismatch();
        test_wrap();
        test_stop_partial();
        test_reset_rdata();
`ifdef PMOD_I2C_TARGET_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
